// File: rtl/axis_frame_demux.sv
// Frame-aware AXI-Stream 1:M demultiplexer.
// Each input frame is steered as a whole to one output port, or it is discarded.
// The destination and drop decision are latched when the frame starts.
// The output stage is a registered output with a one-beat skid register, so the
// input runs at one beat per cycle and the input ready is driven from a register.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | no frame open; s_axis_tready=0; waiting for enable & tvalid
//  ST_ACTIVE | frame open; beats routed to select_reg (or dropped) until tlast
module axis_frame_demux #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  localparam int SEL_W     = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [M_COUNT-1:0]             m_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_axis_tready,
  output logic [M_COUNT-1:0]             m_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser,
  input  logic                           enable,
  input  logic                           drop,
  input  logic [SEL_W-1:0]               select
);

  // One extra bit so out-of-range select values compare correctly for any M_COUNT.
  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(M_COUNT);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t             state, state_next;
  logic [SEL_W-1:0]   select_reg, select_next;
  logic               drop_reg, drop_next;

  logic               ready_int_reg;
  logic               ready_int_early;
  logic               s_accept;
  logic [M_COUNT-1:0] int_tvalid;

  logic [M_COUNT-1:0] m_tvalid_reg, m_tvalid_next;
  logic [M_COUNT-1:0] temp_tvalid_reg, temp_tvalid_next;
  logic               drained;
  logic               store_in_to_out, store_in_to_temp, store_temp_to_out;

  logic [DATA_WIDTH-1:0] m_tdata_reg, temp_tdata_reg;
  logic [KEEP_WIDTH-1:0] m_tkeep_reg, temp_tkeep_reg;
  logic                  m_tlast_reg, temp_tlast_reg;
  logic [USER_WIDTH-1:0] m_tuser_reg, temp_tuser_reg;

  // A dropped frame is drained at full rate regardless of the output stage.
  assign s_axis_tready = (state == ST_ACTIVE) && (drop_reg || ready_int_reg);
  assign s_accept      = s_axis_tvalid && s_axis_tready;

  // Frame state and per-frame routing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      select_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      state      <= state_next;
      select_reg <= select_next;
      drop_reg   <= drop_next;
    end
  end

  // Frame start/end decisions; select/drop/enable only matter in ST_IDLE.
  always_comb begin
    state_next  = state;
    select_next = select_reg;
    drop_next   = drop_reg;
    case (state)
      ST_IDLE: begin
        if (enable && s_axis_tvalid) begin
          state_next  = ST_ACTIVE;
          select_next = select;
          drop_next   = drop || ({1'b0, select} >= SEL_LIMIT);
        end
      end
      ST_ACTIVE: begin
        if (s_accept && s_axis_tlast) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Internal valid vector: one-hot on the latched port for each routed beat.
  always_comb begin
    int_tvalid = '0;
    if (s_accept && !drop_reg) begin
      int_tvalid[select_reg] = 1'b1;
    end
  end

  // Skid control: decide where the incoming beat lands and compute early ready.
  always_comb begin
    drained           = |(m_axis_tready & m_tvalid_reg);
    ready_int_early   = drained || (!(|temp_tvalid_reg) && (!(|m_tvalid_reg) || !(|int_tvalid)));
    m_tvalid_next     = m_tvalid_reg;
    temp_tvalid_next  = temp_tvalid_reg;
    store_in_to_out   = 1'b0;
    store_in_to_temp  = 1'b0;
    store_temp_to_out = 1'b0;
    if (ready_int_reg) begin
      if (drained || !(|m_tvalid_reg)) begin
        m_tvalid_next   = int_tvalid;
        store_in_to_out = 1'b1;
      end else begin
        temp_tvalid_next = int_tvalid;
        store_in_to_temp = 1'b1;
      end
    end else if (drained) begin
      m_tvalid_next     = temp_tvalid_reg;
      temp_tvalid_next  = '0;
      store_temp_to_out = 1'b1;
    end
  end

  // Output-stage control registers; reset empties both output and skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_reg    <= '0;
      temp_tvalid_reg <= '0;
      ready_int_reg   <= 1'b0;
    end else begin
      m_tvalid_reg    <= m_tvalid_next;
      temp_tvalid_reg <= temp_tvalid_next;
      ready_int_reg   <= ready_int_early;
    end
  end

  // Payload registers; contents only matter while the matching valid is set.
  always_ff @(posedge clk) begin
    if (store_in_to_out) begin
      m_tdata_reg <= s_axis_tdata;
      m_tkeep_reg <= s_axis_tkeep;
      m_tlast_reg <= s_axis_tlast;
      m_tuser_reg <= s_axis_tuser;
    end else if (store_temp_to_out) begin
      m_tdata_reg <= temp_tdata_reg;
      m_tkeep_reg <= temp_tkeep_reg;
      m_tlast_reg <= temp_tlast_reg;
      m_tuser_reg <= temp_tuser_reg;
    end
    if (store_in_to_temp) begin
      temp_tdata_reg <= s_axis_tdata;
      temp_tkeep_reg <= s_axis_tkeep;
      temp_tlast_reg <= s_axis_tlast;
      temp_tuser_reg <= s_axis_tuser;
    end
  end

  assign m_axis_tvalid = m_tvalid_reg;
  assign m_axis_tdata  = {M_COUNT{m_tdata_reg}};
  assign m_axis_tkeep  = {M_COUNT{m_tkeep_reg}};
  assign m_axis_tuser  = {M_COUNT{m_tuser_reg}};
  assign m_axis_tlast  = m_tvalid_reg & {M_COUNT{m_tlast_reg}};

endmodule

// File: tb/tb_axis_frame_demux.sv
// Bench for axis_frame_demux: frame table plus hand sequences, per-port scoreboard.
module tb_axis_frame_demux;

  localparam int M  = 4;
  localparam int DW = 8;

  typedef logic [10:0] beat_t;  // {keep, user, last, data}

  typedef struct {
    int sel;
    bit drp;
    int len;
    int base;
    int mid_sel;
    int rmode;
    int exp_port;   // -1: frame must be discarded
  } frame_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic [0:0]      s_axis_tkeep = 1'b1;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic            s_axis_tlast = 1'b0;
  logic [0:0]      s_axis_tuser = 1'b0;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M-1:0]    m_axis_tkeep;
  logic [M-1:0]    m_axis_tvalid;
  logic [M-1:0]    m_axis_tready = '1;
  logic [M-1:0]    m_axis_tlast;
  logic [M-1:0]    m_axis_tuser;
  logic            enable = 1'b0;
  logic            drop = 1'b0;
  logic [1:0]      select = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rmode = 0;
  int cyc_a = 0;
  int cyc_b = 0;

  beat_t q [M][$];
  beat_t held [M];
  bit    stalled [M];

  axis_frame_demux #(.M_COUNT(M), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .USER_WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .enable(enable), .drop(drop), .select(select)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output ready patterns: 0 all ready, 1 port1 toggles 1,0,0,1, 2 random.
  int ph = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: begin
        m_axis_tready    = '1;
        m_axis_tready[1] = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end
      2: m_axis_tready = 4'($urandom_range(0, 15));
      default: m_axis_tready = '1;
    endcase
  end

  // Output monitor: one-hot valid, stability while stalled, scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid != '0) chk($onehot(m_axis_tvalid), "onehot_valid", 32'(m_axis_tvalid), 0);
      for (int i = 0; i < M; i++) begin
        beat_t cur;
        cur = {m_axis_tkeep[i], m_axis_tuser[i], m_axis_tlast[i], m_axis_tdata[i*DW +: DW]};
        if (stalled[i]) begin
          chk(m_axis_tvalid[i] && (cur == held[i]), $sformatf("stall_hold_p%0d", i),
              {m_axis_tvalid[i], 20'd0, cur}, {1'b1, 20'd0, held[i]});
        end
        stalled[i] = 1'b0;
        if (m_axis_tvalid[i]) begin
          if (i == 3 && cur[7:0] == 8'h60 && cyc_b == 0) cyc_b = cyc;
          if (m_axis_tready[i]) begin
            if (q[i].size() == 0) begin
              chk(1'b0, $sformatf("unexpected_beat_p%0d", i), 32'(cur), 0);
            end else begin
              beat_t e;
              e = q[i].pop_front();
              chk(cur == e, $sformatf("beat_p%0d", i), 32'(cur), 32'(e));
              if (i == 0 && e[7:0] == 8'h52) cyc_a = cyc;
            end
          end else begin
            stalled[i] = 1'b1;
            held[i]    = cur;
          end
        end
      end
    end else begin
      for (int i = 0; i < M; i++) stalled[i] = 1'b0;
    end
  end

  task automatic send_frame(input frame_t f);
    int waited;
    rmode = f.rmode;
    for (int b = 0; b < f.len; b++) begin
      s_axis_tdata  = 8'(f.base + b);
      s_axis_tlast  = (b == f.len - 1);
      s_axis_tuser  = 1'(b);
      s_axis_tkeep  = 1'b1;
      s_axis_tvalid = 1'b1;
      if (b == 0) begin
        enable = 1'b1;
        select = 2'(f.sel);
        drop   = f.drp;
      end
      waited = 0;
      @(negedge clk);
      while (!s_axis_tready && waited < 200) begin
        waited++;
        @(negedge clk);
      end
      if (!s_axis_tready) begin
        chk(1'b0, "accept_timeout", 32'(waited), 0);
      end else begin
        if (f.exp_port >= 0)
          q[f.exp_port].push_back({1'b1, 1'(b), s_axis_tlast, s_axis_tdata});
        if (f.drp && b > 0) chk(waited == 0, "drop_ready", 32'(waited), 0);
      end
      @(posedge clk);
      #1;
      if (b == 0) begin
        enable = 1'b0;
        select = 2'(f.mid_sel);
        drop   = ~f.drp;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drop          = 1'b0;
    @(negedge clk);
    chk(s_axis_tready == 1'b0, "idle_gap", 32'(s_axis_tready), 0);
  endtask

  task automatic drain_and_check();
    int n;
    rmode = 0;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < M; i++) chk(q[i].size() == 0, $sformatf("drain_p%0d", i), 32'(q[i].size()), 0);
  endtask

  frame_t tbl [10];

  initial begin
    //        sel drp len base   mid rmode exp
    tbl[0] = '{2, 0, 4, 'h10, 0, 0,  2};
    tbl[1] = '{1, 1, 3, 'h20, 0, 0, -1};
    tbl[2] = '{0, 0, 2, 'h30, 3, 0,  0};
    tbl[3] = '{1, 0, 6, 'h40, 2, 1,  1};
    tbl[4] = '{0, 0, 3, 'h50, 1, 0,  0};
    tbl[5] = '{3, 0, 3, 'h60, 0, 0,  3};
    tbl[6] = '{1, 0, 1, 'h70, 0, 2,  1};
    tbl[7] = '{2, 0, 1, 'h71, 0, 2,  2};
    tbl[8] = '{3, 0, 1, 'h72, 0, 2,  3};
    tbl[9] = '{2, 0, 5, 'h80, 0, 2,  2};

    // Reset state.
    #12;
    chk(m_axis_tvalid == '0, "reset_tvalid", 32'(m_axis_tvalid), 0);
    chk(s_axis_tready == 1'b0, "reset_tready", 32'(s_axis_tready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // enable gate: valid held with enable low must never be accepted.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hA0;
    select        = 2'd1;
    repeat (5) begin
      @(negedge clk);
      chk(s_axis_tready == 1'b0, "enable_gate", 32'(s_axis_tready), 0);
    end
    send_frame('{1, 0, 3, 'hA0, 2, 0, 1});

    for (int k = 0; k < 10; k++) send_frame(tbl[k]);
    drain_and_check();
    chk(cyc_a != 0 && cyc_b > cyc_a, "order_p0_then_p3", 32'(cyc_b), 32'(cyc_a + 1));

    // Reset in the middle of a 5-beat frame after 2 beats.
    @(posedge clk);
    #1;
    enable = 1'b1;
    select = 2'd0;
    drop   = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      int w;
      s_axis_tdata = 8'hC0 + 8'(b);
      s_axis_tlast = 1'b0;
      s_axis_tuser = 1'(b);
      w = 0;
      @(negedge clk);
      while (!s_axis_tready && w < 50) begin
        w++;
        @(negedge clk);
      end
      chk(s_axis_tready, "rst_seq_accept", 32'(s_axis_tready), 1);
      q[0].push_back({1'b1, 1'(b), 1'b0, s_axis_tdata});
      @(posedge clk);
      #1;
      enable = 1'b0;
    end
    s_axis_tdata = 8'hC2;
    #2;
    rst_n = 1'b0;
    #1;
    chk(m_axis_tvalid == '0, "rst_mid_tvalid", 32'(m_axis_tvalid), 0);
    chk(s_axis_tready == 1'b0, "rst_mid_tready", 32'(s_axis_tready), 0);
    for (int i = 0; i < M; i++) q[i].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk(m_axis_tvalid == '0 && s_axis_tready == 1'b0, "post_rst_quiet",
          {s_axis_tready, 27'd0, m_axis_tvalid}, 0);
    end
    s_axis_tvalid = 1'b0;
    @(negedge clk);

    send_frame('{3, 0, 2, 'hD0, 1, 0, 3});
    drain_and_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
